// File: rtl/lma0_pkg.sv
// Shared constants for the lma0 core register file.
package lma0_pkg;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int CW = 16;

  // Architecturally special registers.
  localparam logic [2:0] REG_GP3 = 3'd3;  // LCG accumulator
  localparam logic [2:0] REG_LR  = 3'd7;  // return address for JR

endpackage

// File: rtl/reg_bank_if.sv
// Write/read bus between the lma0 datapath and its register file.
interface reg_bank_if #(
  parameter int DW = lma0_pkg::DW,
  parameter int AW = lma0_pkg::AW,
  parameter int CW = lma0_pkg::CW
);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          hold;
  logic [AW-1:0] ra_addr;
  logic [AW-1:0] rb_addr;
  logic [DW-1:0] ra_data;
  logic [DW-1:0] rb_data;
  logic [DW-1:0] gp3_data;
  logic [DW-1:0] lr_data;
  logic          wb_valid;
  logic [CW-1:0] wr_count;

  // Datapath side: issues writes and read addresses.
  modport master (
    output wr_en, wr_addr, wr_data, hold, ra_addr, rb_addr,
    input  ra_data, rb_data, gp3_data, lr_data, wb_valid, wr_count
  );

  // Register file side.
  modport slave (
    input  wr_en, wr_addr, wr_data, hold, ra_addr, rb_addr,
    output ra_data, rb_data, gp3_data, lr_data, wb_valid, wr_count
  );

endinterface

// File: rtl/reg_bank_wb.sv
// One-entry writeback stage with read-forwarding for the four read ports.
module reg_bank_wb #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          accept_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  // read addresses and raw array values for each port
  input  logic [AW-1:0] ra_addr_i,
  input  logic [AW-1:0] rb_addr_i,
  input  logic [DW-1:0] ra_raw_i,
  input  logic [DW-1:0] rb_raw_i,
  input  logic [DW-1:0] gp3_raw_i,
  input  logic [DW-1:0] lr_raw_i,
  // pending write, committed by the array on the next edge
  output logic          wb_valid_o,
  output logic [AW-1:0] wb_addr_o,
  output logic [DW-1:0] wb_data_o,
  // forwarded read data
  output logic [DW-1:0] ra_data_o,
  output logic [DW-1:0] rb_data_o,
  output logic [DW-1:0] gp3_data_o,
  output logic [DW-1:0] lr_data_o
);
  import lma0_pkg::*;

  logic          wb_valid_q;
  logic [AW-1:0] wb_addr_q;
  logic [DW-1:0] wb_data_q;

  // Newest value wins: the pending write shadows the array entry it targets.
  function automatic logic [DW-1:0] fwd(
    input logic          v,
    input logic [AW-1:0] wa,
    input logic [DW-1:0] wd,
    input logic [AW-1:0] ra,
    input logic [DW-1:0] raw
  );
    return (v && (wa == ra)) ? wd : raw;
  endfunction

  // Capture an accepted write; address/data hold when nothing is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= accept_i;
      if (accept_i) begin
        wb_addr_q <= wr_addr_i;
        wb_data_q <= wr_data_i;
      end
    end
  end

  // Forwarding muxes, purely combinational from state.
  always_comb begin
    ra_data_o  = fwd(wb_valid_q, wb_addr_q, wb_data_q, ra_addr_i, ra_raw_i);
    rb_data_o  = fwd(wb_valid_q, wb_addr_q, wb_data_q, rb_addr_i, rb_raw_i);
    gp3_data_o = fwd(wb_valid_q, wb_addr_q, wb_data_q, AW'(REG_GP3), gp3_raw_i);
    lr_data_o  = fwd(wb_valid_q, wb_addr_q, wb_data_q, AW'(REG_LR), lr_raw_i);
  end

  assign wb_valid_o = wb_valid_q;
  assign wb_addr_o  = wb_addr_q;
  assign wb_data_o  = wb_data_q;

endmodule

// File: rtl/reg_bank.sv
// lma0 architectural register file: 2**AW x DW registers behind a
// registered writeback stage, with forwarded read ports.
module reg_bank #(
  parameter int DW = lma0_pkg::DW,
  parameter int AW = lma0_pkg::AW,
  parameter int CW = lma0_pkg::CW
) (
  input  logic      clk,
  input  logic      rst_n,
  reg_bank_if.slave bus
);
  import lma0_pkg::*;

  localparam int NREG = 1 << AW;

  logic [DW-1:0] regs_q [NREG];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          accept;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;

  // A stall drops the request; the pending writeback is unaffected.
  assign accept = bus.wr_en & ~bus.hold;

  reg_bank_wb #(.DW(DW), .AW(AW)) u_wb (
    .clk        (clk),
    .rst_n      (rst_n),
    .accept_i   (accept),
    .wr_addr_i  (bus.wr_addr),
    .wr_data_i  (bus.wr_data),
    .ra_addr_i  (bus.ra_addr),
    .rb_addr_i  (bus.rb_addr),
    .ra_raw_i   (regs_q[bus.ra_addr]),
    .rb_raw_i   (regs_q[bus.rb_addr]),
    .gp3_raw_i  (regs_q[AW'(REG_GP3)]),
    .lr_raw_i   (regs_q[AW'(REG_LR)]),
    .wb_valid_o (wb_valid),
    .wb_addr_o  (wb_addr),
    .wb_data_o  (wb_data),
    .ra_data_o  (bus.ra_data),
    .rb_data_o  (bus.rb_data),
    .gp3_data_o (bus.gp3_data),
    .lr_data_o  (bus.lr_data)
  );

  // Commit the pending write into the array; no register is hard-wired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_valid) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // Accepted-write counter wraps naturally at 2**CW.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) cnt_d = cnt_q + CW'(1);
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bus.wb_valid = wb_valid;
  assign bus.wr_count = cnt_q;

endmodule
